regfile_sb: RTL

Parametrised multi-port register file with an integrated busy scoreboard and a hardware clear sequencer. It is the next-generation datapath register store for the CPU: NUM_RD combinational read ports, two write ports, per-register pending-write tracking for hazard detection, and a register-by-register zeroing sweep that software can trigger without a global reset.

---
 rtl/regfile_pkg.sv | 35 +++
 rtl/regfile_sb_scoreboard.sv | 69 ++++++
 rtl/regfile_sb.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the regfile_sb register store.
//   - clr_state_e : clear-sweep FSM states (IDLE / SWEEP / DONE)
//   - rd_slot()   : extracts one address field from a packed read-address bus
//   - DEFAULT_*   : default data width and register count
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 16;
  localparam int unsigned DEFAULT_NUM_REGS = 8;

  // Widest supported configuration: 64 registers, 4 read ports.
  localparam int unsigned MAX_ADDR_W = 6;
  localparam int unsigned MAX_RD     = 4;
  localparam int unsigned SLOT_VEC_W = MAX_RD * MAX_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Field k of width w from a packed bus; callers zero-extend the bus to
  // SLOT_VEC_W and truncate the result back to their own address width.
  function automatic logic [MAX_ADDR_W-1:0] rd_slot(
    input logic [SLOT_VEC_W-1:0] vec,
    input int unsigned           k,
    input int unsigned           w
  );
    logic [SLOT_VEC_W-1:0] shifted;
    logic [MAX_ADDR_W-1:0] mask;
    shifted = vec >> (k * w);
    mask    = MAX_ADDR_W'((32'd1 << w) - 32'd1);
    return shifted[MAX_ADDR_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: per-register pending-write (busy) tracking.
//   clk, rst        : clock, asynchronous active-high reset
//   i_set_en/addr   : mark a register busy (issue); wins over a same-cycle clear
//   i_clr0_en/addr  : committed write on port 0 clears busy
//   i_clr1_en/addr  : committed write on port 1 clears busy
//   i_clr_all       : clear every busy bit (start of clear sweep), highest priority
//   i_rd_addr       : packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   i_byp_hit       : per read port, address matches a write committing now;
//                     the lookup then returns the post-edge busy value
//   o_rd_busy       : busy bit of each addressed register
// Enables arrive already qualified (sweep and r0 filtering done by the top).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_R0  = 1,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_set_en,
  input  logic [ADDR_W-1:0]        i_set_addr,
  input  logic                     i_clr0_en,
  input  logic [ADDR_W-1:0]        i_clr0_addr,
  input  logic                     i_clr1_en,
  input  logic [ADDR_W-1:0]        i_clr1_addr,
  input  logic                     i_clr_all,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  input  logic [NUM_RD-1:0]        i_byp_hit,
  output logic [NUM_RD-1:0]        o_rd_busy
);

  logic [NUM_REGS-1:0]   r_busy;
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic [SLOT_VEC_W-1:0] w_rd_addr_pad;

  assign w_rd_addr_pad = SLOT_VEC_W'(i_rd_addr);

  // Clears applied before the set so a same-cycle issue keeps the bit high.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_all) begin
      w_busy_nxt = '0;
    end else begin
      if (i_clr0_en) w_busy_nxt[i_clr0_addr] = 1'b0;
      if (i_clr1_en) w_busy_nxt[i_clr1_addr] = 1'b0;
      if (i_set_en)  w_busy_nxt[i_set_addr]  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  always_comb begin : rd_lookup
    logic [ADDR_W-1:0] a;
    a         = '0;
    o_rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      a = ADDR_W'(rd_slot(w_rd_addr_pad, k, ADDR_W));
      if (i_byp_hit[k]) o_rd_busy[k] = w_busy_nxt[a];
      else              o_rd_busy[k] = r_busy[a];
      if ((ZERO_R0 != 0) && (a == '0)) o_rd_busy[k] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with busy scoreboard and clear sweep.
//   clk, rst            : clock, asynchronous active-high reset
//   wr0_en/addr/data    : write port 0
//   wr1_en/addr/data    : write port 1 (wins on address collision)
//   rd_addr / rd_data   : NUM_RD packed combinational read ports
//   rd_busy             : busy bit of each addressed register
//   issue_en/issue_addr : mark a register as having a write in flight
//   clr_req             : start a register-by-register zeroing sweep (IDLE only)
//   clr_busy            : sweep in progress
//   clr_done            : one-cycle pulse after the last register is zeroed
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and post-write busy state) to matching read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter  int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned ZERO_R0  = 1,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  clr_state_e          r_state;
  clr_state_e          w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_nxt;
  logic                w_sweep_start;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                w_sweep;
  logic                w_wr0_ok;
  logic                w_wr1_ok;
  logic                w_issue_ok;
  logic [NUM_RD-1:0]   w_byp_hit;
  logic [SLOT_VEC_W-1:0] w_rd_addr_pad;

  assign w_sweep  = (r_state == SWEEP);
  assign clr_busy = w_sweep;
  assign clr_done = (r_state == DONE);

  // Qualified enables: everything is dropped while sweeping, and r0 is
  // read-only when ZERO_R0 is set.
  assign w_wr0_ok   = wr0_en   && !w_sweep && !((ZERO_R0 != 0) && (wr0_addr   == '0));
  assign w_wr1_ok   = wr1_en   && !w_sweep && !((ZERO_R0 != 0) && (wr1_addr   == '0));
  assign w_issue_ok = issue_en && !w_sweep && !((ZERO_R0 != 0) && (issue_addr == '0));

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_sweep_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_nxt   = SWEEP;
          w_idx_nxt     = '0;
          w_sweep_start = 1'b1;
        end
      end
      SWEEP: begin
        // Index parks on the last register instead of wrapping.
        if (r_idx == LAST_IDX) w_state_nxt = DONE;
        else                   w_idx_nxt   = r_idx + 1'b1;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- register array ----------------
  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_sweep) begin
      r_regs[r_idx] <= '0;
    end else begin
      if (w_wr0_ok) r_regs[wr0_addr] <= wr0_data;
      if (w_wr1_ok) r_regs[wr1_addr] <= wr1_data;
    end
  end

  // ---------------- read ports ----------------
  assign w_rd_addr_pad = SLOT_VEC_W'(rd_addr);

  always_comb begin : rd_mux
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    a         = '0;
    d         = '0;
    rd_data   = '0;
    w_byp_hit = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      a = ADDR_W'(rd_slot(w_rd_addr_pad, k, ADDR_W));
      d = r_regs[a];
`ifdef REGFILE_BYPASS_EN
      if (w_wr1_ok && (wr1_addr == a)) begin
        d            = wr1_data;
        w_byp_hit[k] = 1'b1;
      end else if (w_wr0_ok && (wr0_addr == a)) begin
        d            = wr0_data;
        w_byp_hit[k] = 1'b1;
      end
`endif
      if ((ZERO_R0 != 0) && (a == '0)) d = '0;
      rd_data[k*DATA_W +: DATA_W] = d;
    end
  end

  // ---------------- scoreboard ----------------
  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_R0  (ZERO_R0),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_set_en    (w_issue_ok),
    .i_set_addr  (issue_addr),
    .i_clr0_en   (w_wr0_ok),
    .i_clr0_addr (wr0_addr),
    .i_clr1_en   (w_wr1_ok),
    .i_clr1_addr (wr1_addr),
    .i_clr_all   (w_sweep_start),
    .i_rd_addr   (rd_addr),
    .i_byp_hit   (w_byp_hit),
    .o_rd_busy   (rd_busy)
  );

endmodule
